// File: rtl/fir_sample_buffer_if.sv
// Sample/read handshake bundle between producer, MAC and sample buffer.
// master: producer+MAC side; slave: fir_sample_buffer.
interface fir_sample_buffer_if #(
  parameter int DATA_W = 18,
  parameter int LANES  = 8,
  parameter int ADDR_W = 11
);
  logic [DATA_W-1:0]       sample_in;
  logic                    sample_valid;
  logic                    sample_ready;
  logic [ADDR_W-1:0]       addr_data;
  logic [LANES*DATA_W-1:0] datain;
  logic                    datain_ready;
  logic                    dataout_ready;
  logic                    busy;

  modport master (
    output sample_in,
    output sample_valid,
    output addr_data,
    output dataout_ready,
    input  sample_ready,
    input  datain,
    input  datain_ready,
    input  busy
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    input  addr_data,
    input  dataout_ready,
    output sample_ready,
    output datain,
    output datain_ready,
    output busy
  );
endinterface

// File: rtl/fir_sample_buffer.sv
// Circular 8-bank sample history feeding the 8-lane FIR MAC.
// Ports: clock, reset (async high), bus (slave: sample in, MAC read/start/done).
module fir_sample_buffer #(
  parameter int DATA_W = 18,
  parameter int LANES  = 8,
  parameter int ADDR_W = 11
) (
  input logic                clock,
  input logic                reset,
  fir_sample_buffer_if.slave bus
);
  localparam int SEL_W = $clog2(LANES);
  localparam int IDX_W = ADDR_W + SEL_W;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_ARM,
    S_BUSY
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nx;
  logic [IDX_W-1:0]        r_wp;
  logic [IDX_W-1:0]        w_wp_nx;
  logic [ADDR_W-1:0]       r_clear_row;
  logic [DATA_W-1:0]       r_hold;
  logic [DATA_W-1:0]       w_hold_nx;
  logic                    r_hold_valid;
  logic                    w_hold_valid_nx;
  logic [LANES*DATA_W-1:0] r_datain;

  logic                    w_clr;
  logic                    w_we;
  logic [DATA_W-1:0]       w_wdata;
  logic [IDX_W-1:0]        w_widx;
  logic                    w_sample_ready;
  logic                    w_datain_ready;

  logic [IDX_W-1:0]        w_base;
  logic [IDX_W-1:0]        w_idx   [LANES];
  logic [ADDR_W-1:0]       w_row   [LANES];
  logic [DATA_W-1:0]       w_rdata [LANES];
  logic [LANES*DATA_W-1:0] w_word;

  // Every commit lands one past the newest sample.
  assign w_widx = r_wp + IDX_W'(1);

  always_comb begin
    w_state_nx      = r_state;
    w_wp_nx         = r_wp;
    w_hold_nx       = r_hold;
    w_hold_valid_nx = r_hold_valid;
    w_clr           = 1'b0;
    w_we            = 1'b0;
    w_wdata         = bus.sample_in;
    w_sample_ready  = 1'b0;
    w_datain_ready  = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr = 1'b1;
        if (r_clear_row == '1) begin
          w_state_nx = S_IDLE;
          w_wp_nx    = '1;
        end
      end
      S_IDLE: begin
        w_sample_ready = 1'b1;
        if (bus.sample_valid) begin
          w_we       = 1'b1;
          w_wp_nx    = w_widx;
          w_state_nx = S_ARM;
        end
      end
      S_ARM: begin
        w_datain_ready = 1'b1;
        w_state_nx     = S_BUSY;
      end
      S_BUSY: begin
        w_sample_ready = ~r_hold_valid;
        if (bus.dataout_ready) begin
          if (r_hold_valid) begin
            w_we            = 1'b1;
            w_wdata         = r_hold;
            w_wp_nx         = w_widx;
            w_hold_valid_nx = 1'b0;
            w_state_nx      = S_ARM;
          end else if (bus.sample_valid) begin
            // Empty hold: the offered sample passes straight through.
            w_we       = 1'b1;
            w_wp_nx    = w_widx;
            w_state_nx = S_ARM;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else if (bus.sample_valid && !r_hold_valid) begin
          w_hold_nx       = bus.sample_in;
          w_hold_valid_nx = 1'b1;
        end
      end
      default: w_state_nx = S_CLEAR;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_CLEAR;
      r_wp         <= '0;
      r_clear_row  <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_datain     <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_wp         <= w_wp_nx;
      r_hold       <= w_hold_nx;
      r_hold_valid <= w_hold_valid_nx;
      if (w_clr) begin
        r_clear_row <= r_clear_row + ADDR_W'(1);
      end
      if (r_state == S_CLEAR) begin
        r_datain <= '0;
      end else begin
        r_datain <= w_word;
      end
    end
  end

  // Bank b holds the lane j = wp[2:0]-b, so its row comes
  // from index wp - 8*addr - j, whose low bits equal b.
  assign w_base = r_wp - {bus.addr_data, {SEL_W{1'b0}}};

  always_comb begin
    for (int b = 0; b < LANES; b++) begin
      w_idx[b] = w_base - IDX_W'(SEL_W'(r_wp[SEL_W-1:0] - SEL_W'(b)));
      w_row[b] = w_idx[b][IDX_W-1:SEL_W];
    end
  end

  for (genvar b = 0; b < LANES; b++) begin : g_bank
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
      if (w_clr) begin
        r_mem[r_clear_row] <= '0;
      end else if (w_we && (w_widx[SEL_W-1:0] == SEL_W'(b))) begin
        r_mem[w_widx[IDX_W-1:SEL_W]] <= w_wdata;
      end
    end

    assign w_rdata[b] = r_mem[w_row[b]];
  end

  // Rotate bank outputs so lane 0 (newest) sits in the top bits.
  always_comb begin
    w_word = '0;
    for (int j = 0; j < LANES; j++) begin
      w_word[(LANES-1-j)*DATA_W +: DATA_W] =
        w_rdata[SEL_W'(r_wp[SEL_W-1:0] - SEL_W'(j))];
    end
  end

  assign bus.sample_ready = w_sample_ready;
  assign bus.datain_ready = w_datain_ready;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.datain       = r_datain;

endmodule

// File: tb/tb_fir_sample_buffer.sv
// Directed self-checking bench for fir_sample_buffer.
// Drives/samples 1 time unit after each rising clock edge.
module tb_fir_sample_buffer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fir_sample_buffer_if bus ();

  fir_sample_buffer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int c = 0; c < 3000; c++) begin
      if (bus.sample_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
      n++;
    end
  endtask

  task automatic do_reset(output bit ok);
    int n;
    reset = 1'b1;
    bus.sample_valid  = 1'b0;
    bus.dataout_ready = 1'b0;
    tick();
    reset = 1'b0;
    wait_ready(ok, n);
  endtask

  task automatic read_word(input logic [10:0] a,
                           output logic [143:0] w);
    bus.addr_data = a;
    tick();
    w = bus.datain;
  endtask

  task automatic scan(output int nz, output int ones);
    logic [143:0] w;
    nz   = 0;
    ones = 0;
    for (int a = 0; a < 2048; a++) begin
      read_word(11'(a), w);
      if (w !== '0) nz++;
      for (int j = 0; j < 8; j++) begin
        if (w[143-18*j -: 18] === 18'd1) ones++;
      end
    end
  endtask

  task automatic send_sample(input logic [17:0] v, output bit ok);
    int n;
    wait_ready(ok, n);
    if (!ok) return;
    bus.sample_in    = v;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid  = 1'b0;
    tick();
    bus.dataout_ready = 1'b1;
    tick();
    bus.dataout_ready = 1'b0;
  endtask

  task automatic test_reset;
    bit ok;
    int n;
    int nz;
    int ones;
    tick();
    tick();
    total++;
    if (bus.sample_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_ready: got %b want 0", bus.sample_ready);
    end
    total++;
    if (bus.datain !== '0) begin
      bad++;
      $display("FAIL rst_datain: got %h want 0", bus.datain);
    end
    total++;
    if (bus.datain_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_dready: got %b want 0", bus.datain_ready);
    end
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_busy: got %b want 1", bus.busy);
    end
    reset = 1'b0;
    wait_ready(ok, n);
    total++;
    if (!ok || n != 2048) begin
      bad++;
      $display("FAIL clear_len: got ok=%0d n=%0d want 2048", ok, n);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_busy: got %b want 0", bus.busy);
    end
    scan(nz, ones);
    total++;
    if (nz != 0) begin
      bad++;
      $display("FAIL clear_zero: got %0d nonzero want 0", nz);
    end
  endtask

  task automatic test_single;
    logic [143:0] exp;
    exp = {18'd5, 126'd0};
    bus.addr_data = 11'd0;
    total++;
    if (bus.datain_ready !== 1'b0) begin
      bad++;
      $display("FAIL single_pre: got %b want 0", bus.datain_ready);
    end
    bus.sample_in    = 18'h00005;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    total++;
    if (bus.datain_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_pulse: got %b want 1", bus.datain_ready);
    end
    tick();
    total++;
    if (bus.datain_ready !== 1'b0) begin
      bad++;
      $display("FAIL single_once: got %b want 0", bus.datain_ready);
    end
    total++;
    if (bus.datain !== exp) begin
      bad++;
      $display("FAIL single_data: got %h want %h", bus.datain, exp);
    end
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL single_busy: got %b want 1", bus.busy);
    end
    bus.dataout_ready = 1'b1;
    tick();
    bus.dataout_ready = 1'b0;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL single_done: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_lanes;
    bit ok;
    bit all_ok;
    logic [143:0] w;
    logic [143:0] exp0;
    logic [143:0] exp1;
    exp0 = {18'd9, 18'd8, 18'd7, 18'd6,
            18'd5, 18'd4, 18'd3, 18'd2};
    exp1 = {18'd1, 126'd0};
    do_reset(ok);
    all_ok = ok;
    for (int v = 1; v <= 9; v++) begin
      send_sample(18'(v), ok);
      all_ok = all_ok & ok;
    end
    total++;
    if (!all_ok) begin
      bad++;
      $display("FAIL lanes_ready: got timeout want ready");
    end
    read_word(11'd0, w);
    total++;
    if (w !== exp0) begin
      bad++;
      $display("FAIL lanes_a0: got %h want %h", w, exp0);
    end
    read_word(11'd1, w);
    total++;
    if (w !== exp1) begin
      bad++;
      $display("FAIL lanes_a1: got %h want %h", w, exp1);
    end
  endtask

  task automatic test_hold;
    bit ok;
    int n;
    logic [143:0] exp;
    exp = {18'd7, 18'd6, 18'd9, 18'd8,
           18'd7, 18'd6, 18'd5, 18'd4};
    bus.addr_data = 11'd0;
    wait_ready(ok, n);
    bus.sample_in    = 18'd6;
    bus.sample_valid = 1'b1;
    tick();
    total++;
    if (bus.sample_ready !== 1'b0) begin
      bad++;
      $display("FAIL arm_ready: got %b want 0", bus.sample_ready);
    end
    bus.sample_in = 18'd7;
    tick();
    total++;
    if (bus.sample_ready !== 1'b1) begin
      bad++;
      $display("FAIL hold_open: got %b want 1", bus.sample_ready);
    end
    tick();
    bus.sample_in = 18'd8;
    total++;
    if (bus.sample_ready !== 1'b0) begin
      bad++;
      $display("FAIL hold_full: got %b want 0", bus.sample_ready);
    end
    tick();
    tick();
    total++;
    if (bus.sample_ready !== 1'b0 || bus.datain_ready !== 1'b0) begin
      bad++;
      $display("FAIL hold_stall: got rdy=%b dr=%b want 0 0",
               bus.sample_ready, bus.datain_ready);
    end
    bus.sample_valid  = 1'b0;
    bus.dataout_ready = 1'b1;
    tick();
    bus.dataout_ready = 1'b0;
    total++;
    if (bus.datain_ready !== 1'b1) begin
      bad++;
      $display("FAIL hold_pulse: got %b want 1", bus.datain_ready);
    end
    tick();
    total++;
    if (bus.datain !== exp) begin
      bad++;
      $display("FAIL hold_data: got %h want %h", bus.datain, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [143:0] exp;
    exp = {18'd11, 18'd7, 18'd6, 18'd9,
           18'd8, 18'd7, 18'd6, 18'd5};
    bus.sample_in     = 18'd11;
    bus.sample_valid  = 1'b1;
    bus.dataout_ready = 1'b1;
    total++;
    if (bus.sample_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready: got %b want 1", bus.sample_ready);
    end
    tick();
    bus.sample_valid  = 1'b0;
    bus.dataout_ready = 1'b0;
    total++;
    if (bus.datain_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_pulse: got %b want 1", bus.datain_ready);
    end
    tick();
    total++;
    if (bus.datain !== exp) begin
      bad++;
      $display("FAIL b2b_data: got %h want %h", bus.datain, exp);
    end
    bus.dataout_ready = 1'b1;
    tick();
    bus.dataout_ready = 1'b0;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_ignored;
    logic [143:0] exp;
    exp = {18'd11, 18'd7, 18'd6, 18'd9,
           18'd8, 18'd7, 18'd6, 18'd5};
    bus.dataout_ready = 1'b1;
    tick();
    bus.dataout_ready = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.datain_ready !== 1'b0 ||
        bus.sample_ready !== 1'b1) begin
      bad++;
      $display("FAIL ign_state: got busy=%b dr=%b rdy=%b want 0 0 1",
               bus.busy, bus.datain_ready, bus.sample_ready);
    end
    total++;
    if (bus.datain !== exp) begin
      bad++;
      $display("FAIL ign_data: got %h want %h", bus.datain, exp);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    int n;
    int nz;
    int ones;
    logic [143:0] w;
    do_reset(ok);
    wait_ready(ok, n);
    bus.sample_in    = 18'd1;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    for (int k = 2; k <= 16385; k++) begin
      tick();
      bus.sample_in     = 18'(k);
      bus.sample_valid  = 1'b1;
      bus.dataout_ready = 1'b1;
      tick();
      bus.sample_valid  = 1'b0;
      bus.dataout_ready = 1'b0;
    end
    tick();
    bus.dataout_ready = 1'b1;
    tick();
    bus.dataout_ready = 1'b0;
    total++;
    if (!ok || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL wrap_idle: got ok=%0d busy=%b want 1 0",
               ok, bus.busy);
    end
    read_word(11'd2047, w);
    total++;
    if (w[17:0] !== 18'd2) begin
      bad++;
      $display("FAIL wrap_a2047: got %0d want 2", w[17:0]);
    end
    read_word(11'd0, w);
    total++;
    if (w[143:126] !== 18'd16385) begin
      bad++;
      $display("FAIL wrap_l0: got %0d want 16385", w[143:126]);
    end
    total++;
    if (w[125:108] !== 18'd16384) begin
      bad++;
      $display("FAIL wrap_l1: got %0d want 16384", w[125:108]);
    end
    scan(nz, ones);
    total++;
    if (ones != 0) begin
      bad++;
      $display("FAIL wrap_gone: got %0d copies want 0", ones);
    end
  endtask

  task automatic test_mid_reset;
    bit ok;
    int n;
    int nz;
    int ones;
    wait_ready(ok, n);
    bus.sample_in    = 18'd100;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    tick();
    bus.sample_in    = 18'd200;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    total++;
    if (bus.sample_ready !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_held: got rdy=%b busy=%b want 0 1",
               bus.sample_ready, bus.busy);
    end
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (bus.datain_ready !== 1'b0 || bus.busy !== 1'b1 ||
        bus.sample_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_async: got dr=%b busy=%b rdy=%b want 0 1 0",
               bus.datain_ready, bus.busy, bus.sample_ready);
    end
    tick();
    reset = 1'b0;
    wait_ready(ok, n);
    total++;
    if (!ok || n != 2048) begin
      bad++;
      $display("FAIL mid_clear: got ok=%0d n=%0d want 2048", ok, n);
    end
    scan(nz, ones);
    total++;
    if (nz != 0) begin
      bad++;
      $display("FAIL mid_zero: got %0d nonzero want 0", nz);
    end
  endtask

  initial begin
    bus.sample_in     = '0;
    bus.sample_valid  = 1'b0;
    bus.addr_data     = '0;
    bus.dataout_ready = 1'b0;
    test_reset();
    test_single();
    test_lanes();
    test_hold();
    test_back_to_back();
    test_ignored();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_sample_buffer.md
Name: fir_sample_buffer

Overview:
- Circular sample buffer that sits in front of the 8-lane FIR MAC engine.
- Accepts one 18-bit input sample per valid/ready handshake and stores it in the history.
- Pulses datain_ready to start an output computation.
- Serves the MAC's addr_data read requests with 144-bit words: 8 consecutive past samples, newest first.
- Holds off the next sample until the MAC reports completion via dataout_ready.

Parameters:
- DATA_W, 18, sample width (fixed at 18 for the MAC).
- LANES, 8, samples per read word (fixed).
- ADDR_W, 11, word address width. History depth = LANES*2^ADDR_W = 16384 samples.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_in  in  18  signed input sample
- sample_valid  in  1  sample_in is valid
- sample_ready  out  1  buffer accepts the sample this cycle
- addr_data  in  11  word address from the MAC (0 = newest 8 samples)
- datain  out  144  registered read word; lane j at bits [143-18j : 126-18j]
- datain_ready  out  1  one-cycle start pulse to the MAC
- dataout_ready  in  1  MAC done pulse; releases the buffer
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high. Reset values:
  - sample_ready=0, datain=0, datain_ready=0, busy=1
  - state=CLEAR, wp=0, clear_row=0, hold_valid=0
- Storage: 8 banks, 2^ADDR_W x 18 each. Sample index i is stored at bank i[2:0], row i[13:3].
- Write pointer: wp is a 14-bit index of the newest committed sample. It wraps modulo 16384. The 16385th-older sample is overwritten.
- Read mapping:
  - For lane j, i = wp - 8*addr_data - j (mod 16384).
  - Per-bank row addresses are computed from this mapping, and the bank outputs are rotated by wp[2:0].
  - datain is registered. Latency is 1 cycle from addr_data, every cycle, in all states except CLEAR (datain=0 in CLEAR).
- States:
  - CLEAR:
    - Writes zero to row clear_row of all 8 banks, then clear_row++.
    - After row 2^ADDR_W-1 is written, go to IDLE with wp=16383, so the first sample lands at index 0.
    - sample_ready=0.
  - IDLE:
    - sample_ready=1.
    - On sample_valid: write sample_in at index wp+1, wp<=wp+1, go to ARM.
  - ARM:
    - datain_ready=1 for exactly this cycle.
    - sample_ready=0.
    - Go to BUSY.
  - BUSY:
    - sample_ready = ~hold_valid. An accepted sample goes into the hold register and sets hold_valid.
    - On dataout_ready with hold_valid=1: commit the held sample (write, wp++), clear hold_valid, go to ARM.
    - On dataout_ready with hold_valid=0: go to IDLE.
    - Simultaneous dataout_ready and sample_valid while hold is empty: the sample is accepted into hold and committed in the same cycle, then go to ARM.
- Write timing: the memory write always completes before the datain_ready pulse. The MAC's first read (addr 0, issued after the pulse) sees the new sample.
- Ignored input: dataout_ready outside BUSY is ignored.
- Flow control: sample_ready is never 1 in CLEAR or ARM. There is no overrun path; stalled samples stay at the producer.
- Arithmetic: all pointer arithmetic is unsigned modulo 2^14. The buffer applies no sign processing to the data.
- Reset mid-operation: state returns to CLEAR immediately and the held sample is discarded. The whole history is re-zeroed before IDLE.

Test Plan:
- Post-reset clear: release reset.
  - sample_ready stays 0 for exactly 2048 cycles after reset deasserts, then goes 1.
  - Reads of addr 0..2047 all return datain=0.
- Single sample: write 18'h00005.
  - datain_ready pulses once, 1 cycle after the handshake.
  - addr 0 -> lane0=5, lanes1-7=0.
- Lane and word split: write samples 1..9, pulsing dataout_ready between them.
  - addr 0 -> lanes 9,8,7,6,5,4,3,2.
  - addr 1 -> lane0=1, rest 0.
- Hold register: during BUSY, offer 7 then 8.
  - 7 is accepted; 8 is stalled with sample_ready=0.
  - On the dataout_ready pulse, 7 is committed and datain_ready re-pulses 1 cycle later.
  - addr 0 lane0=7.
- Wrap-around: write values k=1..16385, each followed by dataout_ready.
  - addr 2047 lane7 = 2; addr 0 lane0 = 16385.
  - Value 1 is no longer present at any address.
- Mid-operation reset: assert reset in BUSY with hold_valid=1.
  - Immediately: datain_ready=0, busy=1, sample_ready=0.
  - After the clear completes, all reads return 0 and the held sample never appears.
